// File: rtl/iwdg_wb_master.sv
// Wishbone master that runs the IWDG bring-up sequence and single-write refresh kicks.
// Optional ST polling between the PR write and the reload key: define IWDG_MASTER_STATUS_POLL_EN.
module iwdg_wb_master #(
    parameter int          IWDG_KR_SIZE  = 16,
    parameter int          IWDG_PR_SIZE  = 3,
    parameter int          IWDG_RLR_SIZE = 12,
    parameter int          IWDG_ST_SIZE  = 2,
    parameter logic [31:0] BASE_ADR      = 32'h0100_0000,
    parameter int          ACK_TIMEOUT   = 16,
    parameter int          POLL_MAX      = 8
) (
    input  logic                     clk_m2s,
    input  logic                     rst_m2s,
    input  logic                     start,
    input  logic                     kick,
    input  logic [IWDG_PR_SIZE-1:0]  cfg_pr,
    input  logic [IWDG_RLR_SIZE-1:0] cfg_rlr,
    output logic [31:0]              adr_m2s,
    output logic [IWDG_KR_SIZE-1:0]  dat_m2s,
    output logic                     we_m2s,
    output logic                     cyc_m2s,
    output logic                     stb_m2s,
    input  logic [IWDG_KR_SIZE-1:0]  dat_s2m,
    input  logic                     ack_s2m,
    output logic                     busy,
    output logic                     done,
    output logic                     running,
    output logic                     err
);

    localparam logic [31:0] IWDG_KR_ADR  = BASE_ADR + 32'h0;
    localparam logic [31:0] IWDG_PR_ADR  = BASE_ADR + 32'h4;
    localparam logic [31:0] IWDG_RLR_ADR = BASE_ADR + 32'h8;
    localparam logic [31:0] IWDG_ST_ADR  = BASE_ADR + 32'hC;
    localparam int          TO_W         = $clog2(ACK_TIMEOUT + 1);

    localparam logic [IWDG_KR_SIZE-1:0] KEY_UNLOCK = IWDG_KR_SIZE'(16'h5555);
    localparam logic [IWDG_KR_SIZE-1:0] KEY_RELOAD = IWDG_KR_SIZE'(16'hAAAA);
    localparam logic [IWDG_KR_SIZE-1:0] KEY_START  = IWDG_KR_SIZE'(16'hCCCC);

    typedef enum logic [3:0] {
        S_IDLE, S_UNLOCK, S_WR_RLR, S_WR_PR, S_POLL_ST,
        S_RELOAD, S_STARTK, S_KICK, S_GAP
    } t_state;

    t_state                   r_state;
    t_state                   r_next;
    logic [31:0]              r_adr;
    logic [IWDG_KR_SIZE-1:0]  r_dat;
    logic                     r_we;
    logic                     r_cyc;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_running;
    logic                     r_err;
    logic                     r_pend;
    logic [IWDG_PR_SIZE-1:0]  r_pr;
    logic [IWDG_RLR_SIZE-1:0] r_rlr;
    logic [TO_W-1:0]          r_to;

    logic                     w_go;
    t_state                   w_go_st;
    logic [TO_W-1:0]          w_to_nxt;
    logic                     w_unused_dat;

`ifdef IWDG_MASTER_STATUS_POLL_EN
    localparam int     PL_W    = $clog2(POLL_MAX + 1);
    localparam t_state PR_NEXT = S_POLL_ST;
    logic [PL_W-1:0]   r_poll;
    logic [PL_W-1:0]   w_poll_nxt;
    assign w_poll_nxt = r_poll + PL_W'(1);
`else
    localparam t_state PR_NEXT = S_RELOAD;
    localparam int     unused_poll_cfg = POLL_MAX + IWDG_ST_SIZE;
`endif

    assign w_to_nxt     = r_to + TO_W'(1);
    assign w_unused_dat = ^dat_s2m;

    assign adr_m2s = r_adr;
    assign dat_m2s = r_dat;
    assign we_m2s  = r_we;
    assign cyc_m2s = r_cyc;
    assign stb_m2s = r_cyc;
    assign busy    = r_busy;
    assign done    = r_done;
    assign running = r_running;
    assign err     = r_err;

    function automatic logic [31:0] f_adr(input t_state s);
        case (s)
            S_WR_RLR:  return IWDG_RLR_ADR;
            S_WR_PR:   return IWDG_PR_ADR;
            S_POLL_ST: return IWDG_ST_ADR;
            default:   return IWDG_KR_ADR;
        endcase
    endfunction

    // RLR/PR are zero-extended onto the KR-wide data bus; ST reads drive zero.
    function automatic logic [IWDG_KR_SIZE-1:0] f_dat(input t_state s,
                                                      input logic [IWDG_PR_SIZE-1:0] pr,
                                                      input logic [IWDG_RLR_SIZE-1:0] rlr);
        case (s)
            S_UNLOCK:         return KEY_UNLOCK;
            S_WR_RLR:         return IWDG_KR_SIZE'(rlr);
            S_WR_PR:          return IWDG_KR_SIZE'(pr);
            S_STARTK:         return KEY_START;
            S_RELOAD, S_KICK: return KEY_RELOAD;
            default:          return '0;
        endcase
    endfunction

    // Decide whether a new transfer launches at the coming edge, and which one.
    always_comb begin
        w_go    = 1'b0;
        w_go_st = S_KICK;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_go    = 1'b1;
                    w_go_st = S_UNLOCK;
                end else if (kick && r_running) begin
                    w_go    = 1'b1;
                    w_go_st = S_KICK;
                end
            end
            S_GAP: begin
                if (r_next != S_IDLE) begin
                    w_go    = 1'b1;
                    w_go_st = r_next;
                end else if (r_pend || kick) begin
                    w_go    = 1'b1;
                    w_go_st = S_KICK;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_m2s or negedge rst_m2s) begin
        if (!rst_m2s) begin
            r_state   <= S_IDLE;
            r_next    <= S_IDLE;
            r_adr     <= '0;
            r_dat     <= '0;
            r_we      <= 1'b0;
            r_cyc     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_running <= 1'b0;
            r_err     <= 1'b0;
            r_pend    <= 1'b0;
            r_pr      <= '0;
            r_rlr     <= '0;
            r_to      <= '0;
`ifdef IWDG_MASTER_STATUS_POLL_EN
            r_poll    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_go) begin
                r_state <= w_go_st;
                r_adr   <= f_adr(w_go_st);
                r_dat   <= f_dat(w_go_st, r_pr, r_rlr);
                r_we    <= (w_go_st != S_POLL_ST);
                r_cyc   <= 1'b1;
                r_busy  <= 1'b1;
                r_to    <= '0;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_err  <= 1'b0;
                        r_pr   <= cfg_pr;
                        r_rlr  <= cfg_rlr;
                        r_pend <= kick;
`ifdef IWDG_MASTER_STATUS_POLL_EN
                        r_poll <= '0;
`endif
                    end
                end
                S_GAP: begin
                    if (r_next == S_IDLE && !w_go) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_next == S_IDLE) begin
                        r_pend <= 1'b0;
                    end else if (kick) begin
                        r_pend <= 1'b1;
                    end
                end
                default: begin
                    if (kick)
                        r_pend <= 1'b1;
                    if (ack_s2m) begin
                        r_cyc   <= 1'b0;
                        r_state <= S_GAP;
                        case (r_state)
                            S_UNLOCK: r_next <= S_WR_RLR;
                            S_WR_RLR: r_next <= S_WR_PR;
                            S_WR_PR:  r_next <= PR_NEXT;
                            S_RELOAD: r_next <= S_STARTK;
                            S_STARTK: begin
                                r_next    <= S_IDLE;
                                r_done    <= 1'b1;
                                r_running <= 1'b1;
                            end
`ifdef IWDG_MASTER_STATUS_POLL_EN
                            S_POLL_ST: begin
                                if (dat_s2m[IWDG_ST_SIZE-1:0] == '0) begin
                                    r_next <= S_RELOAD;
                                end else if (w_poll_nxt == PL_W'(POLL_MAX)) begin
                                    r_state <= S_IDLE;
                                    r_busy  <= 1'b0;
                                    r_err   <= 1'b1;
                                    r_pend  <= 1'b0;
                                end else begin
                                    r_poll <= w_poll_nxt;
                                    r_next <= S_POLL_ST;
                                end
                            end
`endif
                            default:  r_next <= S_IDLE;
                        endcase
                    end else if (w_to_nxt == TO_W'(ACK_TIMEOUT)) begin
                        // Slave never answered: abandon the whole operation.
                        r_cyc   <= 1'b0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                        r_pend  <= 1'b0;
                    end else begin
                        r_to <= w_to_nxt;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iwdg_wb_master.sv
// Scoreboard bench for iwdg_wb_master: expected bus transfers are queued by the stimulus
// and popped by a monitor on every acknowledged transfer; the slave acks in the second strobe cycle.
module tb_iwdg_wb_master;

    localparam logic [31:0] KR  = 32'h0100_0000;
    localparam logic [31:0] PR  = 32'h0100_0004;
    localparam logic [31:0] RLR = 32'h0100_0008;
    localparam logic [31:0] ST  = 32'h0100_000C;
`ifdef IWDG_MASTER_STATUS_POLL_EN
    localparam int NREADS = 1;
`else
    localparam int NREADS = 0;
`endif

    logic        clk_m2s, rst_m2s, start, kick;
    logic [2:0]  cfg_pr;
    logic [11:0] cfg_rlr;
    logic [31:0] adr_m2s;
    logic [15:0] dat_m2s, dat_s2m;
    logic        we_m2s, cyc_m2s, stb_m2s, ack_s2m;
    logic        busy, done, running, err;

    typedef struct {
        logic [31:0] adr;
        logic [15:0] dat;
        logic        we;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] st_q[$];
    logic [15:0] st_default;
    logic [31:0] noack_adr;
    int          n_vec, n_miss, n_done;

    iwdg_wb_master dut (
        .clk_m2s(clk_m2s), .rst_m2s(rst_m2s), .start(start), .kick(kick),
        .cfg_pr(cfg_pr), .cfg_rlr(cfg_rlr),
        .adr_m2s(adr_m2s), .dat_m2s(dat_m2s), .we_m2s(we_m2s),
        .cyc_m2s(cyc_m2s), .stb_m2s(stb_m2s),
        .dat_s2m(dat_s2m), .ack_s2m(ack_s2m),
        .busy(busy), .done(done), .running(running), .err(err)
    );

    initial begin
        clk_m2s = 1'b0;
        forever #5 clk_m2s = ~clk_m2s;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [15:0] d, input logic w);
        exp_t e;
        e.adr = a;
        e.dat = d;
        e.we  = w;
        exp_q.push_back(e);
    endtask

    task automatic push_init(input logic [2:0] p, input logic [11:0] r, input int nreads);
        push(KR, 16'h5555, 1'b1);
        push(RLR, {4'h0, r}, 1'b1);
        push(PR, {13'h0, p}, 1'b1);
        for (int i = 0; i < nreads; i++) push(ST, 16'h0, 1'b0);
        push(KR, 16'hAAAA, 1'b1);
        push(KR, 16'hCCCC, 1'b1);
    endtask

    task automatic pulse_start(input logic [2:0] p, input logic [11:0] r);
        @(negedge clk_m2s);
        start = 1'b1; cfg_pr = p; cfg_rlr = r;
        @(negedge clk_m2s);
        start = 1'b0;
    endtask

    task automatic pulse_kick();
        @(negedge clk_m2s);
        kick = 1'b1;
        @(negedge clk_m2s);
        kick = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk_m2s); #1;
            n++;
        end while (busy && n < budget);
        check("idle_within_budget", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_adr"}, adr_m2s, 0);
        check({tag, "_dat"}, dat_m2s, 0);
        check({tag, "_we"}, we_m2s, 0);
        check({tag, "_cyc"}, cyc_m2s, 0);
        check({tag, "_stb"}, stb_m2s, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_running"}, running, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // Slave: one wait state, then ack; ST reads return queued values, else st_default.
    initial begin
        int wcnt;
        wcnt = 0;
        ack_s2m = 1'b0;
        dat_s2m = '0;
        forever begin
            @(negedge clk_m2s);
            if (!rst_m2s || !cyc_m2s || !stb_m2s || ack_s2m) begin
                ack_s2m = 1'b0;
                wcnt = 0;
            end else if (adr_m2s != noack_adr) begin
                if (wcnt == 0) begin
                    wcnt = 1;
                end else begin
                    ack_s2m = 1'b1;
                    if (!we_m2s) begin
                        if (st_q.size() > 0) dat_s2m = st_q.pop_front();
                        else dat_s2m = st_default;
                    end
                end
            end
        end
    end

    // Monitor: compare each acknowledged transfer, then require an idle bus cycle after it.
    initial begin
        exp_t e;
        logic gap_due;
        gap_due = 1'b0;
        forever begin
            @(negedge clk_m2s); #1;
            if (rst_m2s && cyc_m2s && stb_m2s && ack_s2m) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_transfer_adr", adr_m2s, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("bus_adr", adr_m2s, e.adr);
                    check("bus_we", we_m2s, e.we);
                    if (e.we) check("bus_dat", dat_m2s, e.dat);
                end
                gap_due = 1'b1;
            end else if (gap_due) begin
                gap_due = 1'b0;
                check("gap_cyc", cyc_m2s, 0);
            end
            if (done) n_done++;
        end
    end

    initial begin
        int n, d0;
        logic seen;
        n_vec = 0; n_miss = 0; n_done = 0;
        start = 1'b0; kick = 1'b0; cfg_pr = '0; cfg_rlr = '0;
        st_default = 16'h0; noack_adr = 32'hFFFF_FFFF;
        rst_m2s = 1'b1;
        #3 rst_m2s = 1'b0;
        repeat (2) @(negedge clk_m2s);
        #1;
        check_reset_outputs("reset");
        @(negedge clk_m2s);
        rst_m2s = 1'b1;

        // Kick before the watchdog runs is dropped.
        pulse_kick();
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk_m2s); #1;
            seen = seen | busy | cyc_m2s;
        end
        check("kick_not_running", seen, 0);

        // RLR write never acked: abort after ACK_TIMEOUT strobe cycles.
        noack_adr = RLR;
        push(KR, 16'h5555, 1'b1);
        d0 = n_done;
        pulse_start(3'h2, 12'h345);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_m2s); #1;
            if (cyc_m2s && adr_m2s == RLR) n++;
            else if (n > 0) break;
        end
        check("timeout_cycles", n, 16);
        check("timeout_err", err, 1);
        check("timeout_busy", busy, 0);
        check("timeout_running", running, 0);
        check("timeout_no_done", n_done, d0);
        noack_adr = 32'hFFFF_FFFF;

        // Basic init; accepted start clears err.
        push_init(3'h1, 12'h001, NREADS);
        d0 = n_done;
        pulse_start(3'h1, 12'h001);
        #1;
        check("init_busy_rise", busy, 1);
        check("init_err_cleared", err, 0);
        check("init_cyc_rise", cyc_m2s, 1);
        wait_idle(200);
        check("init_done_pulse", n_done, d0 + 1);
        check("init_running", running, 1);
        check("init_err", err, 0);

        // Single kick: busy for exactly three cycles.
        push(KR, 16'hAAAA, 1'b1);
        pulse_kick();
        #1;
        n = busy ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_m2s); #1;
            if (busy) n++;
            else break;
        end
        check("kick_busy_cycles", n, 3);

        // Two kicks during init merge into one refresh after STARTK.
        push_init(3'h5, 12'hABC, NREADS);
        push(KR, 16'hAAAA, 1'b1);
        d0 = n_done;
        pulse_start(3'h5, 12'hABC);
        repeat (3) @(negedge clk_m2s);
        pulse_kick();
        repeat (2) @(negedge clk_m2s);
        pulse_kick();
        wait_idle(200);
        check("kick2_done", n_done, d0 + 1);

        // start+kick together: init then one kick; a start while busy is ignored.
        push_init(3'h7, 12'hFFF, NREADS);
        push(KR, 16'hAAAA, 1'b1);
        d0 = n_done;
        @(negedge clk_m2s);
        start = 1'b1; kick = 1'b1; cfg_pr = 3'h7; cfg_rlr = 12'hFFF;
        @(negedge clk_m2s);
        start = 1'b0; kick = 1'b0;
        repeat (4) @(negedge clk_m2s);
        pulse_start(3'h2, 12'h111);
        wait_idle(200);
        check("startkick_done", n_done, d0 + 1);

`ifdef IWDG_MASTER_STATUS_POLL_EN
        // ST busy twice, then clear: three reads.
        st_q.push_back(16'h3);
        st_q.push_back(16'h1);
        st_q.push_back(16'h0);
        push_init(3'h3, 12'h020, 3);
        d0 = n_done;
        pulse_start(3'h3, 12'h020);
        wait_idle(300);
        check("poll3_done", n_done, d0 + 1);
        check("poll3_err", err, 0);

        // ST stuck nonzero: POLL_MAX reads, then abort.
        st_default = 16'h2;
        push(KR, 16'h5555, 1'b1);
        push(RLR, 16'h0020, 1'b1);
        push(PR, 16'h0003, 1'b1);
        for (int i = 0; i < 8; i++) push(ST, 16'h0, 1'b0);
        d0 = n_done;
        pulse_start(3'h3, 12'h020);
        wait_idle(300);
        check("pollmax_err", err, 1);
        check("pollmax_no_done", n_done, d0);
        st_default = 16'h0;
`endif

        // Asynchronous reset while the PR write waits for ack.
        noack_adr = PR;
        push(KR, 16'h5555, 1'b1);
        push(RLR, 16'h00F0, 1'b1);
        pulse_start(3'h4, 12'h0F0);
        n = 0;
        while (!(cyc_m2s && adr_m2s == PR) && n < 60) begin
            @(negedge clk_m2s); #1;
            n++;
        end
        check("pr_pending", cyc_m2s && adr_m2s == PR, 1);
        #2 rst_m2s = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk_m2s);
        rst_m2s = 1'b1;
        noack_adr = 32'hFFFF_FFFF;
        push_init(3'h4, 12'h0F0, NREADS);
        d0 = n_done;
        pulse_start(3'h4, 12'h0F0);
        wait_idle(200);
        check("rerun_done", n_done, d0 + 1);
        check("rerun_running", running, 1);

        repeat (3) @(negedge clk_m2s);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
